mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Round-robin controller that shares one `mult` 16x8 multiplier among `NREQ` requesters, such as multiple `cube`-style sequencers or other arithmetic clients. It accepts requests, latches the winner's operands and drives the multiplier's start/busy handshake. When the product is ready it returns the 24-bit result with a one-cycle done pulse to the granted requester. It sits between client FSMs and the single multiplier instance it owns.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `clk_i`  in  1: clock; all state updates on the rising edge.
- `rst_i`  in  1: reset, asynchronous, active-low.
- `req_i`  in  NREQ: per-requester request level.
- `a_bi`  in  NREQ*16: packed operand A; slice i belongs to requester i.
- `b_bi`  in  NREQ*8: packed operand B; slice i belongs to requester i.
- `gnt_o`  out  NREQ: one-hot, one-cycle pulse; the requester's operands have been latched.
- `done_o`  out  NREQ: one-hot, one-cycle pulse; `y_bo` is valid for that requester.
- `y_bo`  out  24: last product; held until the next completion.
- `busy_o`  out  1: high whenever state is not IDLE.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: if any `req_i` bit is set, pick the winner round-robin.
  - Search starts at `last+1` and wraps modulo NREQ.
  - Latch `a_bi`/`b_bi` slices and a winner index register.
  - Pulse `gnt_o[idx]`, then go to ISSUE.
- ISSUE: drive the mult `start_i`=1 for exactly this cycle, then go to WAIT.
- WAIT: hold while mult `busy_o`=1. On the first cycle it is 0:
  - `y_bo`<=mult `y_bo`;
  - pulse `done_o[idx]`;
  - `last`<=idx;
  - go to IDLE.
- Mult contract: `start_i` is sampled only when its `busy_o`=0. Its `busy_o` is high from the cycle after start until the result is valid.
- Requester rules:
  - Hold `req_i` and operands stable until `gnt_o` is seen, then drop `req_i` on the following cycle.
  - `req_i` still high on a later IDLE visit counts as a new request.
- `req_i` is ignored outside IDLE.
- Arithmetic: the product is unsigned, a[15:0]*b[7:0]; the full 24 bits never overflow. Maximum is 65535*255 = 0xFEFF01.
- Reset values: state IDLE, `gnt_o`=0, `done_o`=0, `y_bo`=0, `busy_o`=0, `last`=NREQ-1, so requester 0 wins first.
- Reset mid-operation: all outputs clear immediately and the in-flight product is discarded. The mult instance is reset on the same net, inverted to its active-high polarity. Clients must re-request.
- Simultaneous requests: exactly one grant per IDLE visit. Losers wait; there is no starvation, since each waits at most NREQ-1 services.

## Timing
- Cycle 0: request seen in IDLE.
- Cycle 1: `gnt_o` high; state is ISSUE and mult `start_i` is high.
- Cycle 2 onward: WAIT, mult busy.
- `done_o` and `y_bo` become valid one edge after mult `busy_o` falls.
- Total request-to-done latency is 3 + L_mult cycles, where L_mult is the number of mult busy cycles.
- `busy_o` falls in the same cycle `done_o` is high. A new grant can issue the next cycle.
- `gnt_o` and `done_o` are never high in the same cycle, except in bypass mode.

## Configuration
- `MULT_ARB_ZERO_BYPASS_EN` defined: in IDLE, if the winner's a==0 or b==0:
  - `gnt_o[idx]` and `done_o[idx]` pulse together;
  - `y_bo`<=0 and `last`<=idx;
  - state stays IDLE and the mult is not started;
  - latency is 1 cycle.
- Undefined: zero operands go through the normal ISSUE/WAIT path and return 0.

## Structure
- Shared package `mult_arb_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT);
  - width constants A_W=16, B_W=8, Y_W=24;
  - the maximum NREQ.
- One sub-module: the existing `mult`, instantiated once inside.
- Round-robin pick is inline logic.

## Test plan
- Reset with all requests low, then release reset: all outputs 0 and `busy_o`=0. Assert `rst_i` low mid-WAIT: outputs clear asynchronously, no `done_o` follows.
- Single request, `req_i`=0001, a=300, b=200: `gnt_o`=0001 at cycle 1; `done_o`=0001 with `y_bo`=60000 at 3+L_mult.
- Max operands a=65535, b=255 on requester 2: `y_bo`=0xFEFF01 (16711425), `done_o`=0100.
- `req_i`=1111 held continuously, with each requester re-asserting after service: grant order 0,1,2,3,0. Each product is correct for its own operands.
- Request arrives during WAIT: no grant until after the current `done_o`. It is then granted in the cycle after `busy_o` falls.
- a=0, b=77:
  - with `MULT_ARB_ZERO_BYPASS_EN`: `gnt_o` and `done_o` in the same cycle, `y_bo`=0, mult start never asserted;
  - without it: the full-latency path with `y_bo`=0.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and widths for the round-robin multiplier arbiter and its mult core.
package mult_arb_pkg;

    localparam int A_W      = 16;
    localparam int B_W      = 8;
    localparam int Y_W      = 24;
    localparam int MAX_NREQ = 8;
    localparam int IDX_W    = $clog2(MAX_NREQ);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    function automatic logic [MAX_NREQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        idx_onehot      = '0;
        idx_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/mult_arbiter_mult.sv
// Sequential shift-add 16x8 unsigned multiplier; one B bit per busy cycle.
module mult
    import mult_arb_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [A_W-1:0] a_bi,
    input  logic [B_W-1:0] b_bi,
    input  logic           start_i,
    output logic           busy_o,
    output logic [Y_W-1:0] y_bo
);

    localparam int CTR_W = $clog2(B_W);

    logic [A_W-1:0]   a_q;
    logic [B_W-1:0]   b_q;
    logic [CTR_W-1:0] ctr_q;
    logic [Y_W-1:0]   partial;

    always_comb begin
        partial = '0;
        if (b_q[ctr_q]) begin
            partial = {{(Y_W-A_W){1'b0}}, a_q} << ctr_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q    <= '0;
            b_q    <= '0;
            ctr_q  <= '0;
            busy_o <= 1'b0;
            y_bo   <= '0;
        end else if (!busy_o) begin
            if (start_i) begin
                a_q    <= a_bi;
                b_q    <= b_bi;
                ctr_q  <= '0;
                y_bo   <= '0;
                busy_o <= 1'b1;
            end
        end else begin
            y_bo  <= y_bo + partial;
            ctr_q <= ctr_q + 1'b1;
            if (ctr_q == CTR_W'(B_W-1)) begin
                busy_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one mult core among NREQ requesters.
// Optional zero-operand shortcut: define MULT_ARB_ZERO_BYPASS_EN.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*A_W-1:0]   a_bi,
    input  logic [NREQ*B_W-1:0]   b_bi,
    output logic [NREQ-1:0]       gnt_o,
    output logic [NREQ-1:0]       done_o,
    output logic [Y_W-1:0]        y_bo,
    output logic                  busy_o
);

    localparam int unsigned NREQ_U = NREQ;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    last_q, idx_q, pick_idx;
    logic                pick_valid, bypass;
    logic [MAX_NREQ-1:0] req_ext, pick_oh, idx_oh;
    logic [A_W-1:0]      a_arr [MAX_NREQ];
    logic [B_W-1:0]      b_arr [MAX_NREQ];
    logic [A_W-1:0]      a_q;
    logic [B_W-1:0]      b_q;
    logic                m_start, m_busy, m_rst;
    logic [Y_W-1:0]      m_y;

    // Pad the requester vectors to MAX_NREQ so every index is in range.
    for (genvar g = 0; g < MAX_NREQ; g++) begin : g_unpack
        if (g < NREQ) begin : g_used
            assign req_ext[g] = req_i[g];
            assign a_arr[g]   = a_bi[g*A_W +: A_W];
            assign b_arr[g]   = b_bi[g*B_W +: B_W];
        end else begin : g_pad
            assign req_ext[g] = 1'b0;
            assign a_arr[g]   = '0;
            assign b_arr[g]   = '0;
        end
    end

    always_comb begin
        int unsigned cand;
        cand       = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 1; k <= NREQ_U; k++) begin
            cand = 32'(last_q) + k;
            if (cand >= NREQ_U) begin
                cand = cand - NREQ_U;
            end
            if (!pick_valid && req_ext[cand[IDX_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign pick_oh = idx_onehot(pick_idx);
    assign idx_oh  = idx_onehot(idx_q);

`ifdef MULT_ARB_ZERO_BYPASS_EN
    assign bypass = pick_valid && ((a_arr[pick_idx] == '0) || (b_arr[pick_idx] == '0));
`else
    assign bypass = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid && !bypass) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (!m_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_start = (state_q == ISSUE);
        busy_o  = (state_q != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            gnt_o  <= '0;
            done_o <= '0;
            y_bo   <= '0;
            last_q <= IDX_W'(NREQ - 1);
            idx_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            gnt_o  <= '0;
            done_o <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_o <= pick_oh[NREQ-1:0];
                        idx_q <= pick_idx;
                        a_q   <= a_arr[pick_idx];
                        b_q   <= b_arr[pick_idx];
                        if (bypass) begin
                            done_o <= pick_oh[NREQ-1:0];
                            y_bo   <= '0;
                            last_q <= pick_idx;
                        end
                    end
                end
                WAIT: begin
                    if (!m_busy) begin
                        y_bo   <= m_y;
                        done_o <= idx_oh[NREQ-1:0];
                        last_q <= idx_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_rst = ~rst_i;

    mult u_mult (
        .clk_i   (clk_i),
        .rst_i   (m_rst),
        .a_bi    (a_q),
        .b_bi    (b_q),
        .start_i (m_start),
        .busy_o  (m_busy),
        .y_bo    (m_y)
    );

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: directed vectors, monitor checks grants/completions.
module tb_mult_arbiter;

    localparam int NREQ   = 4;
    localparam int L_MULT = 8;
`ifdef MULT_ARB_ZERO_BYPASS_EN
    localparam bit BYP_EN = 1'b1;
`else
    localparam bit BYP_EN = 1'b0;
`endif

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b0;
    logic [NREQ-1:0]     req_i = '0;
    logic [NREQ*16-1:0]  a_bi  = '0;
    logic [NREQ*8-1:0]   b_bi  = '0;
    logic [NREQ-1:0]     gnt_o;
    logic [NREQ-1:0]     done_o;
    logic [23:0]         y_bo;
    logic                busy_o;

    mult_arbiter #(.NREQ(NREQ)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req_i  (req_i),
        .a_bi   (a_bi),
        .b_bi   (b_bi),
        .gnt_o  (gnt_o),
        .done_o (done_o),
        .y_bo   (y_bo),
        .busy_o (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int idx;
        int y;
        bit byp;
    } txn_t;

    txn_t exp_q[$];
    txn_t cur;
    bit   inflight = 1'b0;
    int   gnt_cyc  = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_txn(input int idx, input int a, input int b, input int y);
        txn_t t;
        a_bi[idx*16 +: 16] = a[15:0];
        b_bi[idx*8 +: 8]   = b[7:0];
        t.idx = idx;
        t.y   = y;
        t.byp = BYP_EN && (a == 0 || b == 0);
        exp_q.push_back(t);
    endtask

    task automatic wait_gnt(input int idx);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!gnt_o[idx] && n < 20);
        chk("gnt_latency", n, 1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (done_o == '0 && n < 40);
        chk("done_seen", int'(done_o != '0), 1);
    endtask

    // Monitor: pairs each grant with the next queued transaction, then checks its completion.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            inflight = 1'b0;
        end else begin
            if (gnt_o != '0) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_gnt: got %b expected none", gnt_o);
                end else begin
                    chk("gnt_while_inflight", int'(inflight), 0);
                    cur = exp_q.pop_front();
                    chk("gnt_onehot", int'(gnt_o), 1 << cur.idx);
                    chk("busy_at_gnt", int'(busy_o), cur.byp ? 0 : 1);
                    inflight = 1'b1;
                    gnt_cyc  = cyc;
                end
            end
            if (done_o != '0) begin
                if (!inflight) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got %b y=%0d expected none", done_o, y_bo);
                end else begin
                    chk("done_onehot", int'(done_o), 1 << cur.idx);
                    chk("y_value", int'(y_bo), cur.y);
                    chk("busy_at_done", int'(busy_o), 0);
                    chk("done_latency", cyc - gnt_cyc, cur.byp ? 0 : L_MULT + 2);
                    inflight = 1'b0;
                end
            end
        end
    end

    initial begin
        int seen;
        int n;

        // Reset state, during and after reset
        repeat (3) @(negedge clk_i);
        chk("rst_gnt", int'(gnt_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_y", int'(y_bo), 0);
        chk("rst_busy", int'(busy_o), 0);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("post_rst_gnt", int'(gnt_o), 0);
        chk("post_rst_done", int'(done_o), 0);
        chk("post_rst_y", int'(y_bo), 0);
        chk("post_rst_busy", int'(busy_o), 0);

        // Single request on requester 0
        push_txn(0, 300, 200, 60000);
        req_i = 4'b0001;
        wait_gnt(0);
        req_i = '0;
        wait_done();
        chk("single_y_hold", int'(y_bo), 60000);

        // Max operands on requester 2
        push_txn(2, 65535, 255, 16711425);
        req_i = 4'b0100;
        wait_gnt(2);
        req_i = '0;
        wait_done();

        // Reset in the middle of WAIT: in-flight product discarded
        push_txn(1, 100, 100, 10000);
        req_i = 4'b0010;
        wait_gnt(1);
        req_i = '0;
        repeat (3) @(negedge clk_i);
        chk("busy_in_wait", int'(busy_o), 1);
        #2 rst_i = 1'b0;
        #1;
        chk("async_rst_busy", int'(busy_o), 0);
        chk("async_rst_y", int'(y_bo), 0);
        chk("async_rst_done", int'(done_o), 0);
        chk("async_rst_gnt", int'(gnt_o), 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (done_o != '0) seen++;
        end
        chk("no_done_after_reset", seen, 0);

        // All requesters held high: order 0,1,2,3,0
        push_txn(0, 1000, 3, 3000);
        push_txn(1, 12345, 100, 1234500);
        push_txn(2, 40000, 200, 8000000);
        push_txn(3, 7, 255, 1785);
        push_txn(0, 1000, 3, 3000);
        req_i = 4'b1111;
        seen  = 0;
        n     = 0;
        while (seen < 5 && n < 100) begin
            @(negedge clk_i);
            n++;
            if (done_o != '0) seen++;
        end
        req_i = '0;
        chk("rr_services", seen, 5);

        // Request arriving during WAIT is granted the cycle after busy_o falls
        push_txn(0, 5, 6, 30);
        req_i = 4'b0001;
        wait_gnt(0);
        req_i = '0;
        repeat (3) @(negedge clk_i);
        push_txn(1, 9, 11, 99);
        req_i = 4'b0010;
        wait_done();
        chk("busy_low_at_done", int'(busy_o), 0);
        @(negedge clk_i);
        chk("gnt_after_wait", int'(gnt_o), 4'b0010);
        req_i = '0;
        wait_done();
        chk("late_req_y", int'(y_bo), 99);

        // Zero operand on requester 3
        push_txn(3, 0, 77, 0);
        req_i = 4'b1000;
        wait_gnt(3);
        req_i = '0;
        if (BYP_EN) begin
            chk("byp_done_with_gnt", int'(done_o), 4'b1000);
            seen = 0;
            repeat (4) begin
                @(negedge clk_i);
                if (busy_o) seen++;
            end
            chk("byp_never_busy", seen, 0);
        end else begin
            chk("zero_no_done_with_gnt", int'(done_o), 0);
            wait_done();
        end
        chk("zero_y", int'(y_bo), 0);

        n = 0;
        while ((exp_q.size() != 0 || inflight) && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("queue_drained", exp_q.size() + int'(inflight), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
